// File: rtl/ddr_port_arbiter_if.sv
// Bus bundle between the requesters, the port arbiter and the LiteDRAM
// native command / write-data port. Requester-side vectors are packed with
// requester k at [k*W +: W].
//   slave  : arbiter view (consumes i_*, drives o_*)
//   master : environment view (drives i_*, consumes o_*)
interface ddr_port_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 27,
    parameter int DW   = 64,
    parameter int LW   = 8
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // init gate
    logic                 i_init_done;

    // requester command channel
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ-1:0]      i_req_we;
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ*LW-1:0]   i_req_len;

    // requester write-data channel
    logic [NREQ-1:0]      i_wvalid;
    logic [NREQ-1:0]      o_wready;
    logic [NREQ*DW-1:0]   i_wdata;
    logic [NREQ-1:0]      i_wlast;

    // downstream command channel
    logic                 o_cmd_valid;
    logic                 i_cmd_ready;
    logic                 o_cmd_we;
    logic [AW-1:0]        o_cmd_addr;
    logic [LW-1:0]        o_cmd_len;
    logic [SW-1:0]        o_cmd_src;

    // downstream write-data channel
    logic                 o_wvalid;
    logic                 i_wready;
    logic [DW-1:0]        o_wdata;
    logic                 o_wlast;

    // status
    logic [NREQ-1:0]      o_grant;
    logic                 o_err_wlast;

    modport slave (
        input  i_init_done,
        input  i_req_valid, i_req_we, i_req_addr, i_req_len,
        output o_req_ready,
        input  i_wvalid, i_wdata, i_wlast,
        output o_wready,
        output o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_len, o_cmd_src,
        input  i_cmd_ready,
        output o_wvalid, o_wdata, o_wlast,
        input  i_wready,
        output o_grant, o_err_wlast
    );

    modport master (
        output i_init_done,
        output i_req_valid, i_req_we, i_req_addr, i_req_len,
        input  o_req_ready,
        output i_wvalid, i_wdata, i_wlast,
        input  o_wready,
        input  o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_len, o_cmd_src,
        output i_cmd_ready,
        input  o_wvalid, o_wdata, o_wlast,
        output i_wready,
        input  o_grant, o_err_wlast
    );

endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing the LiteDRAM command / write-data port between
// NREQ requesters. A grant covers one command plus, for writes, its full
// burst. o_cmd_src tags each command for the read-return demux.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no owner; picks next valid requester once init is done
// S_CMD   | owner's command presented downstream, waiting for ready
// S_WDATA | owner's write beats forwarded, counting down to last beat
module ddr_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 27,
    parameter int DW   = 64,
    parameter int LW   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    ddr_port_arbiter_if.slave     bus
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  rr_q, rr_d;
    logic [SW-1:0]  g_q, g_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic           pick_found;
    logic [SW-1:0]  pick_idx;

    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [LW-1:0]  sel_len;
    logic           sel_wvalid;
    logic [DW-1:0]  sel_wdata;
    logic           sel_wlast;

    logic           last_beat;
    logic           w_fire;

    // Round-robin pick: lowest valid index above the pointer wins; otherwise
    // wrap to the lowest valid index at or below it (pointer itself is last).
    always_comb begin
        logic          hi_found;
        logic          lo_found;
        logic [SW-1:0] hi_idx;
        logic [SW-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.i_req_valid[i]) begin
                if (i > int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = SW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SW'(i);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Select the owner's command and write-data fields.
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_len    = '0;
        sel_wvalid = 1'b0;
        sel_wdata  = '0;
        sel_wlast  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == SW'(i)) begin
                sel_we     = bus.i_req_we[i];
                sel_addr   = bus.i_req_addr[i*AW +: AW];
                sel_len    = bus.i_req_len[i*LW +: LW];
                sel_wvalid = bus.i_wvalid[i];
                sel_wdata  = bus.i_wdata[i*DW +: DW];
                sel_wlast  = bus.i_wlast[i];
            end
        end
    end

    assign last_beat = (cnt_q == '0);
    assign w_fire    = (state_q == S_WDATA) && sel_wvalid && bus.i_wready;

    // State, pointer, owner, beat counter and sticky error registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rr_q    <= SW'(NREQ - 1);
            g_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant, command handshake, burst countdown.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_init_done && pick_found) begin
                    g_d     = pick_idx;
                    rr_d    = pick_idx;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.i_cmd_ready) begin
                    if (sel_we) begin
                        cnt_d   = sel_len;
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                if (w_fire) begin
                    cnt_d = cnt_q - 1'b1;
                    // The requester's own last flag is only cross-checked;
                    // the burst length always comes from the counter.
                    if (sel_wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; all data fields are zeroed outside their active state.
    always_comb begin
        bus.o_cmd_valid = 1'b0;
        bus.o_cmd_we    = 1'b0;
        bus.o_cmd_addr  = '0;
        bus.o_cmd_len   = '0;
        bus.o_cmd_src   = '0;
        bus.o_wvalid    = 1'b0;
        bus.o_wdata     = '0;
        bus.o_wlast     = 1'b0;
        bus.o_req_ready = '0;
        bus.o_wready    = '0;
        bus.o_grant     = '0;
        bus.o_err_wlast = err_q;

        if (state_q == S_CMD) begin
            bus.o_cmd_valid = 1'b1;
            bus.o_cmd_we    = sel_we;
            bus.o_cmd_addr  = sel_addr;
            bus.o_cmd_len   = sel_len;
            bus.o_cmd_src   = g_q;
        end

        if (state_q == S_WDATA) begin
            bus.o_wvalid = sel_wvalid;
            bus.o_wdata  = sel_wdata;
            bus.o_wlast  = last_beat;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (g_q == SW'(i)) begin
                if (state_q != S_IDLE) begin
                    bus.o_grant[i] = 1'b1;
                end
                if (state_q == S_CMD) begin
                    bus.o_req_ready[i] = bus.i_cmd_ready;
                end
                if (state_q == S_WDATA) begin
                    bus.o_wready[i] = bus.i_wready;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: init gating, round-robin order,
// write bursts with back-pressure, wlast cross-check and reset mid-burst.
module tb_ddr_port_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 27;
    localparam int DW   = 64;
    localparam int LW   = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ddr_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) bus ();

    ddr_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [AW-1:0] t_addr  [NREQ];
    logic [LW-1:0] t_len   [NREQ];
    logic [DW-1:0] t_wdata [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign bus.i_req_addr[gi*AW +: AW] = t_addr[gi];
        assign bus.i_req_len[gi*LW +: LW]  = t_len[gi];
        assign bus.i_wdata[gi*DW +: DW]    = t_wdata[gi];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Downstream monitor: records every command and write-beat handshake.
    int            cyc_n = 0;
    int            q_src  [$];
    int            q_cyc  [$];
    logic [AW-1:0] q_addr [$];
    logic [LW-1:0] q_len  [$];
    logic          q_we   [$];
    logic [DW-1:0] q_wd   [$];
    logic          q_wl   [$];
    int            rdy_cnt [NREQ];

    initial for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rstn) begin
            if (bus.o_cmd_valid && bus.i_cmd_ready) begin
                q_src.push_back(int'(bus.o_cmd_src));
                q_cyc.push_back(cyc_n);
                q_addr.push_back(bus.o_cmd_addr);
                q_len.push_back(bus.o_cmd_len);
                q_we.push_back(bus.o_cmd_we);
            end
            if (bus.o_wvalid && bus.i_wready) begin
                q_wd.push_back(bus.o_wdata);
                q_wl.push_back(bus.o_wlast);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.o_req_ready[i] && bus.i_req_valid[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
            end
        end
    end

    task automatic clear_inputs();
        bus.i_req_valid = '0;
        bus.i_req_we    = '0;
        bus.i_wvalid    = '0;
        bus.i_wlast     = '0;
        bus.i_cmd_ready = 1'b0;
        bus.i_wready    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i]  = '0;
            t_len[i]   = '0;
            t_wdata[i] = '0;
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", bus.o_cmd_valid, 0);
        check("rst_wvalid",    bus.o_wvalid, 0);
        check("rst_grant",     bus.o_grant, 0);
        check("rst_ready",     {bus.o_req_ready, bus.o_wready}, 0);
        check("rst_err",       bus.o_err_wlast, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Plays one write transaction from requester k. bad_beat (0-based) adds
    // a spurious requester wlast; rst_after1 pulls reset after the first beat.
    task automatic do_write(input int k, input logic [AW-1:0] addr, input int len,
                            input logic [DW-1:0] base, input int bad_beat,
                            input int cmd_stall, input bit toggle_w, input bit rst_after1);
        int idx = 0;
        int cyc = 0;
        int early = 0;
        int unstable = 0;
        bit cmd_done = 1'b0;
        bit cf;
        bit wf;
        t_addr[k]  = addr;
        t_len[k]   = LW'(len);
        t_wdata[k] = base;
        bus.i_req_we[k]    = 1'b1;
        bus.i_req_valid[k] = 1'b1;
        bus.i_wvalid[k]    = 1'b1;
        bus.i_wlast[k]     = (len == 0) || (bad_beat == 0);
        bus.i_cmd_ready    = (cmd_stall == 0);
        bus.i_wready       = 1'b1;
        while (idx <= len && cyc < 200) begin
            @(negedge clk);
            cf = bus.o_req_ready[k] && bus.i_req_valid[k];
            wf = bus.o_wready[k] && bus.i_wvalid[k];
            if (bus.o_wvalid && !cmd_done) early++;
            if (bus.o_cmd_valid && (bus.o_cmd_addr !== addr)) unstable++;
            @(posedge clk); #1;
            cyc++;
            if (cf) begin
                cmd_done = 1'b1;
                bus.i_req_valid[k] = 1'b0;
            end
            if (wf) begin
                idx++;
                t_wdata[k]     = base + DW'(idx);
                bus.i_wlast[k] = (idx == len) || (idx == bad_beat);
                if (idx > len) bus.i_wvalid[k] = 1'b0;
                if (rst_after1 && idx == 1) begin
                    #2 rstn = 1'b0;
                    return;
                end
            end
            bus.i_cmd_ready = (cyc >= cmd_stall);
            if (toggle_w) bus.i_wready = ~bus.i_wready;
        end
        bus.i_cmd_ready = 1'b1;
        bus.i_wready    = 1'b1;
        check("wr_done",   (idx > len), 1);
        check("wr_early",  early, 0);
        check("cmd_stable", unstable, 0);
    endtask

    initial begin
        int s, w, seen, t, r0, r1;
        clear_inputs();
        bus.i_init_done = 1'b0;

        // Init gate
        apply_reset();
        bus.i_init_done = 1'b0;
        t_addr[0] = 27'h40;
        bus.i_cmd_ready = 1'b1;
        bus.i_req_valid[0] = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_cmd_valid) seen++;
        end
        check("init_block", seen, 0);
        @(posedge clk); #1;
        bus.i_init_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("init_valid", bus.o_cmd_valid, 1);
        check("init_src",   bus.o_cmd_src, 0);
        check("init_addr",  bus.o_cmd_addr, 27'h40);
        check("init_ready", bus.o_req_ready, 2'b01);
        check("init_grant", bus.o_grant, 2'b01);
        @(posedge clk); #1;
        bus.i_req_valid = '0;
        @(negedge clk);
        check("init_idle", bus.o_cmd_valid, 0);

        // Round-robin with both requesters continuously valid
        apply_reset();
        bus.i_init_done = 1'b1;
        bus.i_cmd_ready = 1'b1;
        t_addr[0] = 27'h1000;
        t_addr[1] = 27'h2000;
        s  = q_src.size();
        r0 = rdy_cnt[0];
        r1 = rdy_cnt[1];
        bus.i_req_valid = 2'b11;
        t = 0;
        while ((q_src.size() - s) < 4 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        bus.i_req_valid = '0;
        check("rr_count", q_src.size() - s, 4);
        if (q_src.size() - s >= 4) begin
            for (int j = 0; j < 4; j++) check("rr_src", q_src[s+j], j % 2);
            check("rr_addr1", q_addr[s+1], 27'h2000);
            check("rr_gap",   q_cyc[s+1] - q_cyc[s], 2);
        end
        check("rr_rdy0", rdy_cnt[0] - r0, 2);
        check("rr_rdy1", rdy_cnt[1] - r1, 2);

        // Write burst req1 len=3
        apply_reset();
        bus.i_init_done = 1'b1;
        s = q_src.size();
        w = q_wd.size();
        do_write(1, 27'h100, 3, 64'hA, -1, 0, 1'b0, 1'b0);
        check("wr_ncmd", q_src.size() - s, 1);
        if (q_src.size() > s) begin
            check("wr_src",  q_src[s], 1);
            check("wr_addr", q_addr[s], 27'h100);
            check("wr_len",  q_len[s], 3);
            check("wr_we",   q_we[s], 1);
        end
        check("wr_nbeat", q_wd.size() - w, 4);
        if (q_wd.size() - w >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check("wr_data", q_wd[w+j], 64'hA + 64'(j));
                check("wr_last", q_wl[w+j], (j == 3));
            end
        end
        @(negedge clk);
        check("wr_idle_grant", bus.o_grant, 0);
        check("wr_err", bus.o_err_wlast, 0);

        // Back-pressure: command stall then toggling wready
        s = q_src.size();
        w = q_wd.size();
        do_write(0, 27'h2000, 3, 64'h20, -1, 6, 1'b1, 1'b0);
        check("bp_ncmd",  q_src.size() - s, 1);
        check("bp_nbeat", q_wd.size() - w, 4);
        if (q_wd.size() - w >= 4) begin
            for (int j = 0; j < 4; j++) begin
                check("bp_data", q_wd[w+j], 64'h20 + 64'(j));
                check("bp_last", q_wl[w+j], (j == 3));
            end
        end
        check("bp_err", bus.o_err_wlast, 0);

        // Single-beat write
        w = q_wd.size();
        do_write(0, 27'h300, 0, 64'h55, -1, 0, 1'b0, 1'b0);
        check("len0_nbeat", q_wd.size() - w, 1);
        if (q_wd.size() > w) begin
            check("len0_data", q_wd[w], 64'h55);
            check("len0_last", q_wl[w], 1);
        end
        check("len0_err", bus.o_err_wlast, 0);

        // Requester wlast on beat 2 of len=3
        w = q_wd.size();
        do_write(1, 27'h400, 3, 64'h70, 1, 0, 1'b0, 1'b0);
        check("pc_nbeat", q_wd.size() - w, 4);
        if (q_wd.size() - w >= 4) begin
            for (int j = 0; j < 4; j++) check("pc_last", q_wl[w+j], (j == 3));
        end
        check("pc_err", bus.o_err_wlast, 1);
        do_write(0, 27'h500, 0, 64'h99, -1, 0, 1'b0, 1'b0);
        check("pc_err_sticky", bus.o_err_wlast, 1);

        // Reset mid-burst
        w = q_wd.size();
        do_write(0, 27'h600, 7, 64'hC0, -1, 0, 1'b0, 1'b1);
        #1;
        check("mr_beats",  q_wd.size() - w, 1);
        check("mr_wvalid", bus.o_wvalid, 0);
        check("mr_cmd",    bus.o_cmd_valid, 0);
        check("mr_grant",  bus.o_grant, 0);
        check("mr_ready",  {bus.o_req_ready, bus.o_wready}, 0);
        check("mr_err",    bus.o_err_wlast, 0);
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        s = q_src.size();
        bus.i_cmd_ready = 1'b1;
        bus.i_req_valid = 2'b11;
        t = 0;
        while (q_src.size() == s && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        bus.i_req_valid = '0;
        check("mr_handshake", (q_src.size() > s), 1);
        if (q_src.size() > s) check("mr_first_src", q_src[s], 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
